// File: rtl/memory_burst_rtl.sv
// Burst-capable word memory with byte strobes, a configurable read-data pipeline
// and per-beat OK / address-error / illegal-request responses.
module memory_burst_rtl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4,
  localparam int BL_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BL_W-1:0]       burst_len,
  output logic                  req_ready,
  input  logic                  wvalid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wack,
  output logic [1:0]            response
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int                  IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  localparam logic [1:0] RESP_OK      = 2'b00;
  localparam logic [1:0] RESP_ADDRERR = 2'b01;
  localparam logic [1:0] RESP_ILLEGAL = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] beatAddr_q, beatAddr_d;
  logic [BL_W-1:0]       beatCnt_q, beatCnt_d;
  logic [BL_W-1:0]       burstLen_q, burstLen_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

  logic [RD_LATENCY-1:0] pipeValid_q;
  logic [RD_LATENCY-1:0] pipeErr_q;
  logic [DATA_WIDTH-1:0] pipeData_q [RD_LATENCY];

  logic                  addrErr;
  logic [IDX_W-1:0]      memIdx;
  logic                  lastBeat;
  logic                  acceptWr;
  logic                  acceptRd;
  logic                  illegalReq;
  logic                  beatWrite;
  logic                  beatIssue;
  logic [DATA_WIDTH-1:0] issueData;
  logic                  drainBusy;

  assign addrErr    = ({1'b0, beatAddr_q} >= MEM_LIMIT);
  assign memIdx     = beatAddr_q[IDX_W-1:0];
  assign lastBeat   = (beatCnt_q == burstLen_q);
  assign acceptWr   = (state_q == IDLE) && wr && !rd;
  assign acceptRd   = (state_q == IDLE) && rd && !wr;
  assign illegalReq = (state_q == IDLE) && wr && rd;
  assign beatWrite  = (state_q == WRITE) && wvalid;
  assign beatIssue  = (state_q == READ);
  assign issueData  = addrErr ? '0 : mem_q[memIdx];

  // DRAIN may end once only the output stage still holds a beat.
  always_comb begin
    drainBusy = 1'b0;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      drainBusy = drainBusy | pipeValid_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    beatAddr_d = beatAddr_q;
    beatCnt_d  = beatCnt_q;
    burstLen_d = burstLen_q;
    case (state_q)
      IDLE: begin
        if (acceptWr || acceptRd) begin
          beatAddr_d = addr;
          burstLen_d = burst_len;
          beatCnt_d  = '0;
          state_d    = acceptWr ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wvalid) begin
          beatAddr_d = beatAddr_q + ADDR_WIDTH'(1);
          beatCnt_d  = beatCnt_q + BL_W'(1);
          if (lastBeat) state_d = IDLE;
        end
      end
      READ: begin
        beatAddr_d = beatAddr_q + ADDR_WIDTH'(1);
        beatCnt_d  = beatCnt_q + BL_W'(1);
        if (lastBeat) state_d = DRAIN;
      end
      DRAIN: begin
        if (!drainBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      beatAddr_q <= '0;
      beatCnt_q  <= '0;
      burstLen_q <= '0;
    end else begin
      state_q    <= state_d;
      beatAddr_q <= beatAddr_d;
      beatCnt_q  <= beatCnt_d;
      burstLen_q <= burstLen_d;
    end
  end

  // Stage 0 captures the beat issued this cycle; the last stage drives the outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipeValid_q <= '0;
      pipeErr_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipeData_q[i] <= '0;
      end
    end else begin
      pipeValid_q[0] <= beatIssue;
      pipeErr_q[0]   <= addrErr;
      pipeData_q[0]  <= issueData;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeErr_q[i]   <= pipeErr_q[i-1];
        pipeData_q[i]  <= pipeData_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < MEM_SIZE; w++) begin
        mem_q[w] <= '0;
      end
    end else if (beatWrite && !addrErr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[memIdx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Outputs are forced to their reset values while reset is held low.
  assign req_ready = !reset || (state_q == IDLE);
  assign rvalid    = reset && pipeValid_q[RD_LATENCY-1];
  assign wack      = reset && (beatWrite || illegalReq);

  always_comb begin
    rdata    = '0;
    response = RESP_OK;
    if (rvalid) begin
      rdata    = pipeData_q[RD_LATENCY-1];
      response = pipeErr_q[RD_LATENCY-1] ? RESP_ADDRERR : RESP_OK;
    end else if (wack) begin
      if (illegalReq)   response = RESP_ILLEGAL;
      else if (addrErr) response = RESP_ADDRERR;
    end
  end

endmodule

// File: tb/tb_memory_burst_rtl.sv
// Scoreboard bench for memory_burst_rtl: one instance at read latency 1 and one at
// read latency 3; expected beats are queued at issue and checked by a monitor.
module tb_memory_burst_rtl;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        reset;

  logic        wr, rd, wvalid;
  logic [7:0]  addr;
  logic [1:0]  burstLen;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        reqReady, rvalid, wack;
  logic [31:0] rdata;
  logic [1:0]  response;

  logic        rd3;
  logic [7:0]  addr3;
  logic [1:0]  burstLen3;
  logic        reqReady3, rvalid3, wack3;
  logic [31:0] rdata3;
  logic [1:0]  response3;

  memory_burst_rtl #(.RD_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .burst_len(burstLen),
    .req_ready(reqReady), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb),
    .rvalid(rvalid), .rdata(rdata), .wack(wack), .response(response)
  );

  memory_burst_rtl #(.RD_LATENCY(LAT3)) dut3 (
    .clk(clk), .reset(reset), .wr(1'b0), .rd(rd3), .addr(addr3), .burst_len(burstLen3),
    .req_ready(reqReady3), .wvalid(1'b0), .wdata(32'd0), .wstrb(4'd0),
    .rvalid(rvalid3), .rdata(rdata3), .wack(wack3), .response(response3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        isRead;
    logic [31:0] cyc;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int which, input logic isRead, input int c,
                         input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.isRead = isRead;
    e.cyc    = 32'(c);
    e.data   = d;
    e.resp   = r;
    if (which == 1) q1.push_back(e);
    else            q3.push_back(e);
  endtask

  task automatic compareBeat(input string tag, input exp_t e, input logic actRv,
                             input logic [31:0] actData, input logic [1:0] actResp);
    checkOutput({tag, " kind(rvalid)"}, 32'(actRv), 32'(e.isRead));
    checkOutput({tag, " cycle"}, 32'(cyc), e.cyc);
    if (e.isRead) checkOutput({tag, " rdata"}, actData, e.data);
    checkOutput({tag, " response"}, 32'(actResp), 32'(e.resp));
  endtask

  // Pops one expectation for every cycle a DUT presents rvalid or wack.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rvalid || wack) begin
        if (q1.size() == 0) checkOutput("dut1 unexpected beat", 32'({rvalid, wack}), 32'd0);
        else begin
          e = q1.pop_front();
          compareBeat("dut1", e, rvalid, rdata, response);
        end
      end
      if (rvalid3 || wack3) begin
        if (q3.size() == 0) checkOutput("dut3 unexpected beat", 32'({rvalid3, wack3}), 32'd0);
        else begin
          e = q3.pop_front();
          compareBeat("dut3", e, rvalid3, rdata3, response3);
        end
      end
    end
  endtask

  task automatic waitIdle(input int which, input string name);
    int n = 0;
    while (((which == 1) ? reqReady : reqReady3) !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checkOutput(name, 32'((which == 1) ? reqReady : reqReady3), 32'd1);
  endtask

  task automatic applyRead(input logic [7:0] a, input logic [1:0] len,
                           input logic [127:0] expData, input logic [7:0] expResp);
    for (int i = 0; i <= int'(len); i++) begin
      pushExp(1, 1'b1, cyc + 1 + i + LAT1, expData[i*32 +: 32], expResp[i*2 +: 2]);
    end
    rd       = 1'b1;
    addr     = a;
    burstLen = len;
    step();
    rd = 1'b0;
    waitIdle(1, "dut1 read returns to idle");
  endtask

  task automatic applyWrite(input logic [7:0] a, input logic [1:0] len, input logic [127:0] d,
                            input logic [15:0] s, input logic [3:0] gaps, input logic [7:0] expResp);
    wr       = 1'b1;
    addr     = a;
    burstLen = len;
    step();
    wr = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps[i]) step();
      wvalid = 1'b1;
      wdata  = d[i*32 +: 32];
      wstrb  = s[i*4 +: 4];
      pushExp(1, 1'b0, cyc, 32'd0, expResp[i*2 +: 2]);
      step();
      wvalid = 1'b0;
    end
    waitIdle(1, "dut1 write returns to idle");
  endtask

  task automatic applyIllegal(input logic [7:0] a, input logic [31:0] d);
    pushExp(1, 1'b0, cyc, 32'd0, 2'b11);
    wr    = 1'b1;
    rd    = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = 4'hF;
    step();
    wr = 1'b0;
    rd = 1'b0;
    waitIdle(1, "dut1 illegal stays idle");
  endtask

  task automatic applyStimulus();
    reset = 1'b0;
    wr = 1'b0; rd = 1'b0; wvalid = 1'b0; addr = '0; burstLen = '0; wdata = '0; wstrb = '0;
    rd3 = 1'b0; addr3 = '0; burstLen3 = '0;
    repeat (3) step();
    checkOutput("reset req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset wack", 32'(wack), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset response", 32'(response), 32'd0);
    checkOutput("reset dut3 req_ready", 32'(reqReady3), 32'd1);
    reset = 1'b1;
    step();

    applyRead(8'd3, 2'd0, 128'd0, 8'h00);
    applyWrite(8'd2, 2'd3, {32'h44, 32'h33, 32'h22, 32'h11}, 16'hFFFF, 4'b1010, 8'h00);
    applyRead(8'd2, 2'd3, {32'h44, 32'h33, 32'h22, 32'h11}, 8'h00);

    applyWrite(8'd5, 2'd0, {96'd0, 32'hAABBCCDD}, 16'h000F, 4'b0000, 8'h00);
    applyWrite(8'd5, 2'd0, {96'd0, 32'h11223344}, 16'h0005, 4'b0000, 8'h00);
    applyRead(8'd5, 2'd0, {96'd0, 32'hAA22CC44}, 8'h00);

    applyWrite(8'd15, 2'd0, {96'd0, 32'hDEADBEEF}, 16'h000F, 4'b0000, 8'h00);
    applyRead(8'd14, 2'd3, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 8'b01_01_00_00);

    // Address 255 is out of range and the second beat wraps to word 0.
    applyWrite(8'd255, 2'd1, {64'd0, 32'h0BADF00D, 32'hFFFFFFFF}, 16'h00FF, 4'b0000, 8'b00_01);
    applyRead(8'd255, 2'd1, {64'd0, 32'h0BADF00D, 32'h0}, 8'b00_01);

    applyIllegal(8'd2, 32'hFFFFFFFF);
    applyRead(8'd2, 2'd0, {96'd0, 32'h11}, 8'h00);
    checkOutput("dut1 idle rdata", rdata, 32'd0);
    checkOutput("dut1 idle response", 32'(response), 32'd0);

    // Latency-3 instance: reset lands before the first beat can emerge.
    rd3 = 1'b1; addr3 = 8'd0; burstLen3 = 2'd3;
    step();
    rd3 = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checkOutput("dut3 req_ready after reset", 32'(reqReady3), 32'd1);
    checkOutput("dut3 rvalid after reset", 32'(rvalid3), 32'd0);
    repeat (8) step();

    pushExp(3, 1'b1, cyc + 1 + LAT3, 32'd0, 2'b00);
    rd3 = 1'b1; addr3 = 8'd1; burstLen3 = 2'd0;
    step();
    rd3 = 1'b0;
    waitIdle(3, "dut3 read returns to idle");
    repeat (2) step();

    checkOutput("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
    checkOutput("dut3 scoreboard drained", 32'(q3.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/memory_burst_rtl.md
MEMORY_BURST_RTL -- requirements
Module: memory_burst_rtl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter MEM_SIZE, default 16, number of words; at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read-data latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter MAX_BURST, default 4, maximum beats per burst; power of 2.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  reset; synchronous, active-low.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port rd  input  1  read request.
REQ-010 SHALL have port addr  input  ADDR_WIDTH  burst start address.
REQ-011 SHALL have port burst_len  input  $clog2(MAX_BURST)  beats minus one.
REQ-012 SHALL have port req_ready  output  1  request accepted when high.
REQ-013 SHALL have port wvalid  input  1  write beat present.
REQ-014 SHALL have port wdata  input  DATA_WIDTH  write beat data.
REQ-015 SHALL have port wstrb  input  DATA_WIDTH/8  per-byte write enable.
REQ-016 SHALL have port rvalid  output  1  rdata and response valid for a read beat.
REQ-017 SHALL have port rdata  output  DATA_WIDTH  read beat data.
REQ-018 SHALL have port wack  output  1  write beat consumed; response valid.
REQ-019 SHALL have port response  output  2  00 OK, 01 address error, 11 illegal request.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ, DRAIN; req_ready high only in IDLE.
REQ-021 SHALL accept a request in IDLE when exactly one of wr/rd is high; latch addr and burst_len; go to WRITE or READ next cycle.
REQ-022 SHALL, when wr and rd are both high in IDLE, perform no access, pulse wack for one cycle with response 11, and stay in IDLE.
REQ-023 SHALL, in WRITE, consume one beat per cycle with wvalid high, writing only the bytes whose wstrb bit is set; cycles with wvalid low stall the burst without timeout.
REQ-024 SHALL pulse wack with each consumed write beat in the same cycle; the write is visible to reads from the next cycle.
REQ-025 SHALL, in READ, issue one beat per cycle unconditionally; each beat returns rvalid, rdata and response exactly RD_LATENCY cycles after issue.
REQ-026 SHALL increment the beat address by 1 per beat, truncated to ADDR_WIDTH bits (wraps to 0).
REQ-027 SHALL treat a beat address >= MEM_SIZE as an error: no array write, rdata 0, response 01; the remaining beats continue.
REQ-028 SHALL leave READ after the last beat issues: to DRAIN while beats are in flight, then to IDLE when the pipeline is empty; leave WRITE to IDLE the cycle after the last beat.
REQ-029 SHALL ignore wr, rd, addr and burst_len outside IDLE.
REQ-030 SHALL drive rdata 0 and response 00 whenever neither rvalid nor wack is high.

Reset
REQ-031 SHALL, while reset is low at a clock edge, enter IDLE, clear all memory words to 0, flush the read pipeline, and drive req_ready 1, rvalid 0, wack 0, rdata 0, response 00.
REQ-032 SHALL abort any burst when reset is asserted mid-operation: pending beats are dropped, no rvalid or wack is produced for them, and the next access starts from IDLE.

Verification
REQ-033 Bench SHALL cover: reset, then a read at addr 3, burst_len 0 -> rvalid 1 cycle after issue, rdata 0, response 00.
REQ-034 Bench SHALL cover: write burst at addr 2, burst_len 3, data 11,22,33,44, wstrb F, wvalid gaps; then read the same range -> four wack, then rdata 11,22,33,44 on consecutive rvalid cycles.
REQ-035 Bench SHALL cover: write 0xAABBCCDD, then 0x11223344 with wstrb 0101 to the same word -> read returns 0xAA22CC44.
REQ-036 Bench SHALL cover: MEM_SIZE 16, read at addr 14, burst_len 3 -> responses 00,00,01,01 with rdata 0 on the error beats.
REQ-037 Bench SHALL cover: wr and rd high together -> single wack with response 11, memory unchanged; then RD_LATENCY 3 and reset low during a read burst -> no further rvalid, req_ready 1 on the cycle after reset.
